// File: rtl/frame_sequencer_ctrl.sv
// Frame-timing controller: free-running state/cycle counters, run/stop/loop FSM,
// frame timestamp and DMA-reset resynchronisation for the AXIS frame builder.
module frame_sequencer_ctrl #(
  parameter int STATES_PER_CYCLE = 80,
  parameter int CYCLES_PER_FRAME = 35,
  parameter int TS_WIDTH         = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                reset_timestamp,
  input  logic [31:0]         loop_count,
  input  logic                dma_rst,
  input  logic                dp_stall,
  output logic [6:0]          state_idx,
  output logic [5:0]          cycle_idx,
  output logic                frame_last,
  output logic                tx_active,
  output logic                frame_abort,
  output logic [TS_WIDTH-1:0] timestamp,
  output logic [31:0]         frames_sent,
  output logic [31:0]         stall_count,
  output logic [1:0]          run_state,
  output logic                loop_done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DONE   = 2'd2,
    ST_RESYNC = 2'd3
  } run_state_t;

  localparam logic [6:0] STATE_MAX = 7'(STATES_PER_CYCLE - 1);
  localparam logic [5:0] CYCLE_MAX = 6'(CYCLES_PER_FRAME - 1);

  logic [6:0]          state_q, state_d;
  logic [5:0]          cycle_q, cycle_d;
  logic                frame_last_q, frame_last_d;
  logic                tx_active_q, tx_active_d;
  logic                frame_abort_q, frame_abort_d;
  logic [TS_WIDTH-1:0] timestamp_q, timestamp_d;
  logic [31:0]         frames_sent_q, frames_sent_d;
  logic [31:0]         stall_count_q, stall_count_d;
  run_state_t          run_state_q, run_state_d;
  logic                loop_done_q, loop_done_d;
  logic [31:0]         frames_next;

  always_comb begin
    state_d       = state_q;
    cycle_d       = cycle_q;
    timestamp_d   = timestamp_q;
    run_state_d   = run_state_q;
    tx_active_d   = tx_active_q;
    frame_abort_d = 1'b0;
    frames_sent_d = frames_sent_q;
    stall_count_d = stall_count_q;
    frames_next   = frames_sent_q + 32'd1;

    // Counters free-run in every FSM state; frame_last is registered from their next value.
    if (state_q == STATE_MAX) begin
      state_d = 7'd0;
      cycle_d = (cycle_q == CYCLE_MAX) ? 6'd0 : cycle_q + 6'd1;
    end else begin
      state_d = state_q + 7'd1;
    end
    frame_last_d = (state_d == STATE_MAX) && (cycle_d == CYCLE_MAX);

    if (frame_last_q) begin
      timestamp_d = (!enable && reset_timestamp) ? '0 : timestamp_q + TS_WIDTH'(1);
    end

    if (tx_active_q && dp_stall && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end

    // dma_rst pre-empts every transition, including one that falls on a boundary.
    if (dma_rst) begin
      run_state_d   = ST_RESYNC;
      tx_active_d   = 1'b0;
      frame_abort_d = tx_active_q;
    end else begin
      case (run_state_q)
        ST_IDLE: begin
          if (frame_last_q && enable) begin
            run_state_d   = ST_RUN;
            tx_active_d   = 1'b1;
            frames_sent_d = 32'd0;
            stall_count_d = 32'd0;
          end
        end
        ST_RUN: begin
          if (frame_last_q) begin
            frames_sent_d = frames_next;
            if (!enable) begin
              run_state_d = ST_IDLE;
              tx_active_d = 1'b0;
            end else if ((loop_count != 32'd0) && (frames_next >= loop_count)) begin
              run_state_d = ST_DONE;
              tx_active_d = 1'b0;
            end
          end
        end
        ST_DONE: begin
          tx_active_d = 1'b0;
          if (!enable) begin
            run_state_d = ST_IDLE;
          end
        end
        ST_RESYNC: begin
          tx_active_d = 1'b0;
          if (frame_last_q) begin
            run_state_d = ST_IDLE;
          end
        end
        default: begin
          run_state_d = ST_IDLE;
          tx_active_d = 1'b0;
        end
      endcase
    end

    loop_done_d = (run_state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= 7'd0;
      cycle_q       <= 6'd0;
      frame_last_q  <= 1'b0;
      tx_active_q   <= 1'b0;
      frame_abort_q <= 1'b0;
      timestamp_q   <= '0;
      frames_sent_q <= 32'd0;
      stall_count_q <= 32'd0;
      run_state_q   <= ST_IDLE;
      loop_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cycle_q       <= cycle_d;
      frame_last_q  <= frame_last_d;
      tx_active_q   <= tx_active_d;
      frame_abort_q <= frame_abort_d;
      timestamp_q   <= timestamp_d;
      frames_sent_q <= frames_sent_d;
      stall_count_q <= stall_count_d;
      run_state_q   <= run_state_d;
      loop_done_q   <= loop_done_d;
    end
  end

  assign state_idx   = state_q;
  assign cycle_idx   = cycle_q;
  assign frame_last  = frame_last_q;
  assign tx_active   = tx_active_q;
  assign frame_abort = frame_abort_q;
  assign timestamp   = timestamp_q;
  assign frames_sent = frames_sent_q;
  assign stall_count = stall_count_q;
  assign run_state   = run_state_q;
  assign loop_done   = loop_done_q;

endmodule
